// File: rtl/otf_converter.sv
// On-the-fly converter: folds an MSD-first signed-digit stream into a two's-complement
// result by keeping Q and QM = Q-1 and choosing between them each digit, so no carry chain is needed.
module otf_converter #(
    parameter int N_DIGITS    = 8,
    parameter int SKIP_DIGITS = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    p_digit,
    input  logic                          p_valid,
    output logic [N_DIGITS:0]             result,
    output logic                          result_valid,
    output logic                          busy,
    output logic [$clog2(N_DIGITS+1)-1:0] digit_cnt,
    output logic                          digit_err
);

    localparam int W  = N_DIGITS + 1;
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int SW = (SKIP_DIGITS > 0) ? $clog2(SKIP_DIGITS + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(N_DIGITS - 1);
    localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP_DIGITS > 0) ? SKIP_DIGITS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CONV
    } state_t;

    state_t        state;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  qm_reg;
    logic [W-1:0]  q_next;
    logic [W-1:0]  qm_next;
    logic [CW-1:0] cnt;
    logic [SW-1:0] skip_cnt;

    // The illegal code 2'b11 falls into the default arm and is therefore treated as a zero digit.
    always_comb begin
        q_next  = {q_reg[W-2:0], 1'b0};
        qm_next = {qm_reg[W-2:0], 1'b1};
        case (p_digit)
            2'b10: begin
                q_next  = {q_reg[W-2:0], 1'b1};
                qm_next = {q_reg[W-2:0], 1'b0};
            end
            2'b01: begin
                q_next  = {qm_reg[W-2:0], 1'b1};
                qm_next = {qm_reg[W-2:0], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            q_reg        <= '0;
            qm_reg       <= '1;
            cnt          <= '0;
            skip_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            digit_err    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (start) begin
                state     <= (SKIP_DIGITS > 0) ? SKIP : CONV;
                q_reg     <= '0;
                qm_reg    <= '1;
                cnt       <= '0;
                skip_cnt  <= '0;
                digit_err <= 1'b0;
            end else begin
                case (state)
                    SKIP: begin
                        if (p_valid) begin
                            if (skip_cnt == SKIP_LAST) begin
                                state    <= CONV;
                                skip_cnt <= '0;
                            end else begin
                                skip_cnt <= skip_cnt + 1'b1;
                            end
                        end
                    end
                    CONV: begin
                        if (p_valid) begin
                            q_reg  <= q_next;
                            qm_reg <= qm_next;
                            cnt    <= cnt + 1'b1;
                            if (p_digit == 2'b11)
                                digit_err <= 1'b1;
                            if (cnt == CNT_LAST) begin
                                result       <= q_next;
                                result_valid <= 1'b1;
                                state        <= IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign digit_cnt = cnt;

endmodule

// File: tb/tb_otf_converter.sv
// Scoreboard bench for otf_converter: a reference Q/QM model predicts each result and
// the invariant, with one instance using no skip and one discarding three leading digits.
module tb_otf_converter;

    typedef logic [1:0] dig_arr_t [8];

    logic       clk;
    logic       rst_n;
    logic       start0, valid0, start3, valid3;
    logic [1:0] digit0, digit3;
    logic [8:0] result0, result3;
    logic       rv0, rv3, busy0, busy3, err0, err3;
    logic [3:0] cnt0, cnt3;

    int errors = 0;
    int checks = 0;

    logic [8:0] sb0[$];
    logic [8:0] sb3[$];

    logic [8:0] m_q, m_qm;
    logic       m_err;

    otf_converter #(.N_DIGITS(8), .SKIP_DIGITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .p_digit(digit0), .p_valid(valid0),
        .result(result0), .result_valid(rv0), .busy(busy0), .digit_cnt(cnt0), .digit_err(err0)
    );

    otf_converter #(.N_DIGITS(8), .SKIP_DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .p_digit(digit3), .p_valid(valid3),
        .result(result3), .result_valid(rv3), .busy(busy3), .digit_cnt(cnt3), .digit_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs on the selected instance and returns at the following negedge.
    task automatic applyStimulus(input int sel, input logic st, input logic v, input logic [1:0] d);
        if (sel == 0) begin
            start0 = st; valid0 = v; digit0 = d;
        end else begin
            start3 = st; valid3 = v; digit3 = d;
        end
        @(negedge clk);
        start0 = 1'b0; valid0 = 1'b0; digit0 = 2'b00;
        start3 = 1'b0; valid3 = 1'b0; digit3 = 2'b00;
    endtask

    task automatic modelStep(input logic [1:0] d);
        logic [8:0] nq, nqm;
        case (d)
            2'b10:   begin nq = {m_q[7:0], 1'b1};  nqm = {m_q[7:0], 1'b0};  end
            2'b01:   begin nq = {m_qm[7:0], 1'b1}; nqm = {m_qm[7:0], 1'b0}; end
            default: begin nq = {m_q[7:0], 1'b0};  nqm = {m_qm[7:0], 1'b1}; end
        endcase
        if (d == 2'b11) m_err = 1'b1;
        m_q  = nq;
        m_qm = nqm;
    endtask

    task automatic startConversion();
        applyStimulus(0, 1'b1, 1'b1, 2'b10);
        m_q = '0; m_qm = '1; m_err = 1'b0;
        checkOutput("busy_after_start", busy0, 1);
        checkOutput("cnt_after_start", cnt0, 0);
        checkOutput("err_after_start", err0, 0);
    endtask

    task automatic runConversion(input dig_arr_t digs, input int max_gap, input bit check_inv);
        logic [8:0] exp_qm;
        startConversion();
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) applyStimulus(0, 1'b0, 1'b0, 2'b10);
            if (gap > 0) checkOutput("cnt_hold_gap", cnt0, i);
            modelStep(digs[i]);
            if (i == 7) sb0.push_back(m_q);
            applyStimulus(0, 1'b0, 1'b1, digs[i]);
            if (check_inv) begin
                exp_qm = m_q - 9'd1;
                checkOutput("q_step", dut0.q_reg, m_q);
                checkOutput("qm_invariant", dut0.qm_reg, exp_qm);
            end
            if (i == 7) checkOutput("rv_latency", rv0, 1);
            else        checkOutput("rv_early", rv0, 0);
        end
        checkOutput("digit_err", err0, m_err);
        checkOutput("busy_done", busy0, 0);
        applyStimulus(0, 1'b0, 1'b0, 2'b00);
        checkOutput("rv_pulse", rv0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rv0) begin
            if (sb0.size() == 0) checkOutput("sb0_unexpected", 1, 0);
            else checkOutput("sb0_result", result0, sb0.pop_front());
        end
        if (rst_n && rv3) begin
            if (sb3.size() == 0) checkOutput("sb3_unexpected", 1, 0);
            else checkOutput("sb3_result", result3, sb3.pop_front());
        end
    end

    initial begin
        dig_arr_t digs;
        rst_n = 1'b0;
        start0 = 1'b0; valid0 = 1'b0; digit0 = 2'b00;
        start3 = 1'b0; valid3 = 1'b0; digit3 = 2'b00;
        repeat (2) @(negedge clk);
        checkOutput("rst_result", result0, 0);
        checkOutput("rst_rv", rv0, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_cnt", cnt0, 0);
        checkOutput("rst_err", err0, 0);
        checkOutput("rst_qm", dut0.qm_reg, 9'h1FF);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] all plus digits");
        digs = '{default: 2'b10};
        runConversion(digs, 0, 1'b0);
        checkOutput("hold_result_255", result0, 9'h0FF);

        $display("[TB] all minus digits and plus-then-minus");
        digs = '{default: 2'b01};
        runConversion(digs, 0, 1'b1);
        digs = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        runConversion(digs, 0, 1'b1);

        $display("[TB] mixed digits with gaps");
        digs = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        runConversion(digs, 3, 1'b1);
        checkOutput("mixed_hold", result0, 9'h067);

        $display("[TB] abort after three digits");
        startConversion();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b1, 2'b10);
        checkOutput("cnt_before_abort", cnt0, 3);
        digs = '{default: 2'b10};
        runConversion(digs, 0, 1'b0);

        $display("[TB] illegal digit");
        digs = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        runConversion(digs, 0, 1'b0);
        checkOutput("err_sticky", err0, 1);
        checkOutput("err_result", result0, 9'h0EF);
        startConversion();

        $display("[TB] reset mid-conversion");
        applyStimulus(0, 1'b0, 1'b1, 2'b11);
        applyStimulus(0, 1'b0, 1'b1, 2'b10);
        checkOutput("err_before_rst", err0, 1);
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b1, 2'b10);
        checkOutput("midrst_result", result0, 0);
        checkOutput("midrst_rv", rv0, 0);
        checkOutput("midrst_busy", busy0, 0);
        checkOutput("midrst_cnt", cnt0, 0);
        checkOutput("midrst_err", err0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 1'b1, 2'b10);
        checkOutput("idle_ignores_valid", cnt0, 0);

        $display("[TB] skip three digits");
        applyStimulus(3, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            checkOutput("skip_busy", busy3, 1);
            applyStimulus(3, 1'b0, 1'b1, 2'b01);
            checkOutput("skip_cnt", cnt3, 0);
        end
        sb3.push_back(9'h0FF);
        for (int i = 0; i < 8; i++) begin
            checkOutput("conv3_busy", busy3, 1);
            applyStimulus(3, 1'b0, 1'b1, 2'b10);
        end
        checkOutput("skip_rv", rv3, 1);
        checkOutput("skip_busy_done", busy3, 0);
        applyStimulus(3, 1'b0, 1'b0, 2'b00);

        checkOutput("sb0_drained", sb0.size(), 0);
        checkOutput("sb3_drained", sb3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
